// File: rtl/stability_monitor.sv
// Stability monitor: watches a data word while a qualifier flag is high and
// queues KEEP/LOSE events for a downstream consumer through a small FIFO.
module stability_monitor #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flag,
    input  logic [WIDTH-1:0]     data,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic                 evt_kind,
    output logic [WIDTH-1:0]     evt_old,
    output logic [WIDTH-1:0]     evt_new,
    output logic [CNT_WIDTH-1:0] evt_cycles,
    output logic                 overflow,
    output logic [CNT_WIDTH-1:0] err_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic KIND_KEEP = 1'b0;
    localparam logic KIND_LOSE = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_t;

    typedef struct packed {
        logic                 kind;
        logic [WIDTH-1:0]     old_v;
        logic [WIDTH-1:0]     new_v;
        logic [CNT_WIDTH-1:0] cycles;
    } evt_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_last_data;
    logic [WIDTH-1:0]     w_data_nxt;
    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH-1:0] w_count_nxt;
    logic [CNT_WIDTH-1:0] w_count_inc;
    logic                 r_stable;
    logic                 w_stable_nxt;
    logic                 w_push;
    logic                 w_lose;
    evt_t                 w_push_evt;

    evt_t                 r_mem [DEPTH];
    logic [AW:0]          r_wptr;
    logic [AW:0]          r_rptr;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_wr;
    logic                 w_drop;
    evt_t                 w_head;
    logic                 r_overflow;
    logic [CNT_WIDTH-1:0] r_err_count;

    assign w_count_inc = (r_count == CNT_MAX) ? r_count : r_count + CNT_WIDTH'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_last_data <= '0;
            r_count     <= '0;
            r_stable    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_last_data <= w_data_nxt;
            r_count     <= w_count_nxt;
            r_stable    <= w_stable_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_data_nxt   = r_last_data;
        w_count_nxt  = r_count;
        w_stable_nxt = r_stable;
        w_push       = 1'b0;
        w_lose       = 1'b0;
        w_push_evt   = '0;
        case (r_state)
            IDLE: begin
                if (flag) begin
                    w_state_nxt  = TRACK;
                    w_data_nxt   = data;
                    w_count_nxt  = CNT_WIDTH'(1);
                    w_stable_nxt = 1'b1;
                end
            end
            TRACK: begin
                if (flag) begin
                    w_count_nxt = w_count_inc;
                    // Each change is reported against the previous cycle's word.
                    if (data != r_last_data) begin
                        w_push       = 1'b1;
                        w_lose       = 1'b1;
                        w_push_evt   = '{kind: KIND_LOSE, old_v: r_last_data,
                                         new_v: data, cycles: r_count};
                        w_stable_nxt = 1'b0;
                        w_data_nxt   = data;
                    end
                end else begin
                    w_state_nxt = IDLE;
                    if (r_stable) begin
                        w_push     = 1'b1;
                        w_push_evt = '{kind: KIND_KEEP, old_v: r_last_data,
                                       new_v: r_last_data, cycles: r_count};
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = !w_empty && evt_ready;
    // A full queue still accepts a push when the head leaves on the same edge.
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr[AW-1:0]] <= w_push_evt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_overflow  <= 1'b0;
            r_err_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_lose && (r_err_count != CNT_MAX)) begin
                r_err_count <= r_err_count + CNT_WIDTH'(1);
            end
        end
    end

    // Head fields are gated so an empty queue presents all zeros.
    assign w_head     = r_mem[r_rptr[AW-1:0]];
    assign evt_valid  = !w_empty;
    assign evt_kind   = evt_valid ? w_head.kind   : 1'b0;
    assign evt_old    = evt_valid ? w_head.old_v  : '0;
    assign evt_new    = evt_valid ? w_head.new_v  : '0;
    assign evt_cycles = evt_valid ? w_head.cycles : '0;
    assign overflow   = r_overflow;
    assign err_count  = r_err_count;

endmodule

// File: doc/stability_monitor.md
STABILITY_MONITOR -- requirements
Module: stability_monitor

Interface
REQ-001 Parameter WIDTH, default 8, monitored data width in bits.
REQ-002 Parameter CNT_WIDTH, default 16, cycle-count and error-count width.
REQ-003 Parameter DEPTH, default 4, event queue entries; power of two, at least 2.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 flag  in  1  qualifier; data must hold stable while flag=1.
REQ-008 data  in  WIDTH  monitored word.
REQ-009 evt_valid  out  1  queue head holds an event.
REQ-010 evt_ready  in  1  consumer accepts head when evt_valid=1.
REQ-011 evt_kind  out  1  0=KEEP (info), 1=LOSE (error).
REQ-012 evt_old  out  WIDTH  KEEP: held value; LOSE: value before change.
REQ-013 evt_new  out  WIDTH  LOSE: changed-to value; KEEP: equals evt_old.
REQ-014 evt_cycles  out  CNT_WIDTH  cycles tracked when event raised.
REQ-015 overflow  out  1  sticky; an event was dropped on a full queue.
REQ-016 err_count  out  CNT_WIDTH  saturating LOSE count, dropped LOSE events included.

Function
REQ-017 The block SHALL sample flag and data only on rising clk edges; registers last_flag, last_data, count, stable.
REQ-018 States IDLE and TRACK; state equals the registered last_flag.
REQ-019 IDLE, flag=1: go TRACK; count=1, stable=1, last_data=data; no event.
REQ-020 TRACK, flag=1, data==last_data: count+=1, saturating at 2^CNT_WIDTH-1; no event.
REQ-021 TRACK, flag=1, data!=last_data: push LOSE {old=last_data, new=data, cycles=count}; stable=0; count+=1 (saturating); last_data=data.
REQ-022 Each subsequent change in the same TRACK window SHALL push another LOSE, compared against the previous cycle's data, not the entry value.
REQ-023 TRACK, flag=0: push KEEP {old=new=last_data, cycles=count} only if stable=1; go IDLE.
REQ-024 IDLE, flag=0: no action.
REQ-025 A pushed event SHALL appear on evt_valid the edge after the sampling edge (1-cycle latency) when the queue was empty.
REQ-026 Queue is FIFO; evt_* SHALL be valid whenever evt_valid=1 and hold stable until popped.
REQ-027 Pop occurs on an edge with evt_valid=1 and evt_ready=1.
REQ-028 Push on a full queue with a pop on the same edge SHALL succeed; occupancy unchanged.
REQ-029 Push on a full queue without a pop SHALL drop the event and set overflow; queue contents unchanged.
REQ-030 Read/write pointers SHALL wrap modulo DEPTH; full/empty SHALL be distinguished by an extra pointer bit or occupancy counter.
REQ-031 err_count SHALL increment on every LOSE detection, including dropped ones, saturating at 2^CNT_WIDTH-1.
REQ-032 evt_ready with an empty queue SHALL have no effect.

Reset
REQ-033 rst=1 SHALL immediately force: state IDLE, last_flag=0, last_data=0, count=0, stable=0, queue empty, evt_valid=0, evt_kind=0, evt_old=0, evt_new=0, evt_cycles=0, overflow=0, err_count=0.
REQ-034 Reset during TRACK SHALL discard the window without emitting KEEP; queued events are lost.
REQ-035 flag=1 on the first edge after reset release SHALL enter TRACK per REQ-019.

Verification
REQ-036 flag=1 for 5 edges with data=8'hA5, then flag=0 -> one KEEP {old=A5, cycles=5}, evt_valid high one edge after the flag=0 sample; err_count=0.
REQ-037 flag=1, data A5,A5,3C,3C, then flag=0 -> one LOSE {old=A5, new=3C, cycles=2}, no KEEP, err_count=1.
REQ-038 DEPTH=4, evt_ready=0, 5 LOSE detections -> 4 queued, overflow=1, err_count=5; then evt_ready=1 -> 4 pops in order, evt_valid falls.
REQ-039 Queue full, evt_ready=1, LOSE detected on same edge -> occupancy remains 4, overflow stays 0, new event is last out.
REQ-040 rst asserted mid-TRACK after 3 cycles, released with flag=0 -> no events, all outputs zero.
REQ-041 CNT_WIDTH=4, flag=1 stable for 20 edges -> KEEP with cycles=15 (saturated).
